// File: rtl/enemy_missile_launcher.sv
// Single enemy missile: launches from a top-of-screen X toward one of three ground
// targets and walks a Bresenham line one pixel per move tick. Optional trail origin
// outputs are enabled by defining ENEMY_MISSILE_TRAIL_EN.
module enemy_missile_launcher #(
    parameter int COORD_W      = 10,
    parameter int TOP_Y        = 0,
    parameter int GROUND_Y     = 440,
    parameter int TARGET_X0    = 80,
    parameter int TARGET_X1    = 320,
    parameter int TARGET_X2    = 560,
    parameter int MOVE_DIV     = 2,
    parameter int COOLDOWN_CYC = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         target_sel,
    input  logic [COORD_W-1:0] spawn_x,
    input  logic               launch_req,
    input  logic               frame_tick,
    input  logic               destroyed,
    output logic [COORD_W-1:0] missile_x,
    output logic [COORD_W-1:0] missile_y,
    output logic               active,
    output logic               busy,
    output logic               impact,
    output logic [1:0]         impact_target,
    output logic               killed
`ifdef ENEMY_MISSILE_TRAIL_EN
    ,
    output logic [COORD_W-1:0] trail_x0,
    output logic [COORD_W-1:0] trail_y0
`endif
);

    localparam int E_W  = COORD_W + 2;
    localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int CD_W  = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
    localparam logic [COORD_W-1:0] TOP_C = COORD_W'(TOP_Y);
    localparam logic [COORD_W-1:0] GND_C = COORD_W'(GROUND_Y);
    localparam logic [COORD_W-1:0] DY    = COORD_W'(GROUND_Y - TOP_Y);

    typedef enum logic [1:0] {IDLE, FLY, IMPACT, COOLDOWN} state_t;

    state_t                  state, state_n;
    logic [COORD_W-1:0]      x, x_n, y, y_n, tx, tx_n, dx, dx_n;
    logic [COORD_W-1:0]      remaining, rem_n;
    logic                    sx_neg, sx_neg_n;
    logic signed [E_W-1:0]   err, err_n, e2, dx_s, dy_s;
    logic [DIV_W-1:0]        div_cnt, div_n;
    logic [CD_W-1:0]         cd_cnt, cd_n;
    logic [1:0]              tgt, tgt_n;
    logic                    killed_q, killed_n;

    logic [COORD_W-1:0]      launch_tx, launch_dx, launch_rem;
    logic [1:0]              launch_tgt;
    logic                    launch_neg;
    logic signed [E_W-1:0]   launch_err;

    // Indices 3..7 are not real targets; they fold onto the centre one.
    always_comb begin
        launch_tx  = COORD_W'(TARGET_X1);
        launch_tgt = 2'd1;
        case (target_sel)
            3'd0: begin
                launch_tx  = COORD_W'(TARGET_X0);
                launch_tgt = 2'd0;
            end
            3'd2: begin
                launch_tx  = COORD_W'(TARGET_X2);
                launch_tgt = 2'd2;
            end
            default: ;
        endcase
        launch_neg = 1'b0;
        launch_dx  = launch_tx - spawn_x;
        if (launch_tx < spawn_x) begin
            launch_neg = 1'b1;
            launch_dx  = spawn_x - launch_tx;
        end
        launch_err = $signed({2'b00, launch_dx}) - $signed({2'b00, DY});
        launch_rem = (launch_dx > DY) ? launch_dx : DY;
    end

    always_comb begin
        state_n  = state;
        x_n      = x;
        y_n      = y;
        tx_n     = tx;
        dx_n     = dx;
        sx_neg_n = sx_neg;
        err_n    = err;
        rem_n    = remaining;
        div_n    = div_cnt;
        cd_n     = cd_cnt;
        tgt_n    = tgt;
        killed_n = 1'b0;
        dx_s     = $signed({2'b00, dx});
        dy_s     = $signed({2'b00, DY});
        e2       = err + err;
        case (state)
            IDLE: begin
                if (launch_req) begin
                    state_n  = FLY;
                    x_n      = spawn_x;
                    y_n      = TOP_C;
                    tx_n     = launch_tx;
                    dx_n     = launch_dx;
                    sx_neg_n = launch_neg;
                    err_n    = launch_err;
                    rem_n    = launch_rem;
                    tgt_n    = launch_tgt;
                    div_n    = '0;
                end
            end
            FLY: begin
                // A kill on the same cycle as the last step suppresses the impact.
                if (destroyed) begin
                    state_n  = COOLDOWN;
                    cd_n     = '0;
                    killed_n = 1'b1;
                end else if (frame_tick) begin
                    if (div_cnt == DIV_W'(MOVE_DIV - 1)) begin
                        div_n = '0;
                        if (e2 > -dy_s) begin
                            err_n = err_n - dy_s;
                            x_n   = sx_neg ? (x - COORD_W'(1)) : (x + COORD_W'(1));
                        end
                        if (e2 < dx_s) begin
                            err_n = err_n + dx_s;
                            y_n   = y + COORD_W'(1);
                        end
                        rem_n = remaining - COORD_W'(1);
                        if (remaining == COORD_W'(1)) begin
                            state_n = IMPACT;
                            x_n     = tx;
                            y_n     = GND_C;
                        end
                    end else begin
                        div_n = div_cnt + DIV_W'(1);
                    end
                end
            end
            IMPACT: begin
                state_n = COOLDOWN;
                cd_n    = '0;
            end
            COOLDOWN: begin
                if (cd_cnt == CD_W'(COOLDOWN_CYC - 1)) begin
                    state_n = IDLE;
                end else begin
                    cd_n = cd_cnt + CD_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            tx        <= '0;
            dx        <= '0;
            sx_neg    <= 1'b0;
            err       <= '0;
            remaining <= '0;
            div_cnt   <= '0;
            cd_cnt    <= '0;
            tgt       <= '0;
            killed_q  <= 1'b0;
        end else begin
            state     <= state_n;
            x         <= x_n;
            y         <= y_n;
            tx        <= tx_n;
            dx        <= dx_n;
            sx_neg    <= sx_neg_n;
            err       <= err_n;
            remaining <= rem_n;
            div_cnt   <= div_n;
            cd_cnt    <= cd_n;
            tgt       <= tgt_n;
            killed_q  <= killed_n;
        end
    end

`ifdef ENEMY_MISSILE_TRAIL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            trail_x0 <= '0;
            trail_y0 <= '0;
        end else if (state == IDLE && launch_req) begin
            trail_x0 <= spawn_x;
            trail_y0 <= TOP_C;
        end
    end
`endif

    assign missile_x     = x;
    assign missile_y     = y;
    assign active        = (state == FLY);
    assign busy          = (state != IDLE);
    assign impact        = (state == IMPACT);
    assign impact_target = tgt;
    assign killed        = killed_q;

endmodule

// File: tb/tb_enemy_missile_launcher.sv
// Directed bench for enemy_missile_launcher: a table of full flights plus
// hand-written reset, kill and held-request sequences.
module tb_enemy_missile_launcher;
    localparam int CW = 10;
    localparam int CD = 8;
    localparam int GY = 440;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    target_sel;
    logic [CW-1:0] spawn_x;
    logic          launch_req, frame_tick, destroyed;
    logic [CW-1:0] missile_x, missile_y;
    logic          active, busy, impact, killed;
    logic [1:0]    impact_target;

    logic          launch_req2, frame_tick2;
    logic [CW-1:0] missile_x2, missile_y2;
    logic          active2, busy2, impact2, killed2;
    logic [1:0]    impact_target2;
`ifdef ENEMY_MISSILE_TRAIL_EN
    logic [CW-1:0] trail_x0, trail_y0, trail_x0_2, trail_y0_2;
`endif

    enemy_missile_launcher #(.MOVE_DIV(1), .COOLDOWN_CYC(CD)) u_dut (
        .clk(clk), .reset(reset), .target_sel(target_sel), .spawn_x(spawn_x),
        .launch_req(launch_req), .frame_tick(frame_tick), .destroyed(destroyed),
        .missile_x(missile_x), .missile_y(missile_y), .active(active), .busy(busy),
        .impact(impact), .impact_target(impact_target), .killed(killed)
`ifdef ENEMY_MISSILE_TRAIL_EN
        , .trail_x0(trail_x0), .trail_y0(trail_y0)
`endif
    );

    enemy_missile_launcher #(.MOVE_DIV(2), .COOLDOWN_CYC(CD)) u_dut2 (
        .clk(clk), .reset(reset), .target_sel(target_sel), .spawn_x(spawn_x),
        .launch_req(launch_req2), .frame_tick(frame_tick2), .destroyed(destroyed),
        .missile_x(missile_x2), .missile_y(missile_y2), .active(active2), .busy(busy2),
        .impact(impact2), .impact_target(impact_target2), .killed(killed2)
`ifdef ENEMY_MISSILE_TRAIL_EN
        , .trail_x0(trail_x0_2), .trail_y0(trail_y0_2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    sel;
        logic [CW-1:0] sx;
        int            tx;
        int            tgt;
        int            steps;
        int            dir;
    } vec_t;

    vec_t vecs[7];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        int steps, guard, px, py, ddx, ddy, path_ok;
        @(negedge clk);
        check("idle_before", busy, 0);
        target_sel = vecs[i].sel;
        spawn_x    = vecs[i].sx;
        launch_req = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        launch_req = 1'b0;
        check("launch_active", active, 1);
        check("launch_x", missile_x, vecs[i].sx);
        check("launch_y", missile_y, 0);
        check("launch_tgt", impact_target, vecs[i].tgt);
        steps = 0; guard = 0; path_ok = 1;
        while (active && guard < 3000) begin
            steps++;
            px = int'(missile_x);
            py = int'(missile_y);
            @(negedge clk);
            guard++;
            ddx = int'(missile_x) - px;
            ddy = int'(missile_y) - py;
            if (vecs[i].dir > 0 && ddx < 0) path_ok = 0;
            if (vecs[i].dir < 0 && ddx > 0) path_ok = 0;
            if (vecs[i].dir == 0 && int'(missile_x) != int'(vecs[i].sx)) path_ok = 0;
            if (ddx > 1 || ddx < -1 || ddy < 0 || ddy > 1) path_ok = 0;
            if (int'(missile_y) > GY) path_ok = 0;
        end
        check("fly_steps", steps, vecs[i].steps);
        check("path_ok", path_ok, 1);
        check("impact", impact, 1);
        check("final_x", missile_x, vecs[i].tx);
        check("final_y", missile_y, GY);
        check("impact_tgt", impact_target, vecs[i].tgt);
        check("no_kill", killed, 0);
        @(negedge clk);
        check("impact_once", impact, 0);
        check("cool_busy", busy, 1);
        repeat (CD - 1) @(negedge clk);
        check("cool_end_busy", busy, 1);
        @(negedge clk);
        check("busy_fall", busy, 0);
        check("hold_x", missile_x, vecs[i].tx);
        check("hold_y", missile_y, GY);
    endtask

    initial begin
        int guard, steps, seen_impact, seen_kill, early;
        vecs[0] = '{3'd1, 10'd320, 320, 1, 440, 0};
        vecs[1] = '{3'd2, 10'd0,   560, 2, 560, 1};
        vecs[2] = '{3'd0, 10'd600, 80,  0, 520, -1};
        vecs[3] = '{3'd5, 10'd100, 320, 1, 440, 1};
        vecs[4] = '{3'd3, 10'd500, 320, 1, 440, -1};
        vecs[5] = '{3'd7, 10'd320, 320, 1, 440, 0};
        vecs[6] = '{3'd2, 10'd560, 560, 2, 440, 0};

        reset = 1'b1; target_sel = '0; spawn_x = '0; launch_req = 1'b0;
        frame_tick = 1'b0; destroyed = 1'b0; launch_req2 = 1'b0; frame_tick2 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_x", missile_x, 0);
        check("rst_y", missile_y, 0);
        check("rst_active", active, 0);
        check("rst_busy", busy, 0);
        check("rst_impact", impact, 0);
        check("rst_tgt", impact_target, 0);
        check("rst_killed", killed, 0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Reset while in flight at y=100, then relaunch one cycle after release.
        target_sel = 3'd1; spawn_x = 10'd320; launch_req = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        launch_req = 1'b0;
        guard = 0;
        while (missile_y != 10'd100 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("mid_y100", missile_y, 100);
        check("mid_active", active, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_x", missile_x, 0);
        check("mrst_y", missile_y, 0);
        check("mrst_active", active, 0);
        check("mrst_busy", busy, 0);
        check("mrst_impact", impact, 0);
        check("mrst_tgt", impact_target, 0);
        check("mrst_killed", killed, 0);
        @(negedge clk);
        launch_req = 1'b1;
        @(negedge clk);
        launch_req = 1'b0;
        check("relaunch_active", active, 1);
        check("relaunch_y", missile_y, 0);
        check("relaunch_tgt", impact_target, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Kill on the cycle of the final step: no impact, straight to cooldown.
        @(negedge clk);
        launch_req = 1'b1;
        @(negedge clk);
        launch_req = 1'b0;
        guard = 0;
        while (missile_y != 10'd439 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("kill_setup_y", missile_y, 439);
        check("kill_setup_active", active, 1);
        destroyed = 1'b1;
        @(negedge clk);
        check("kill_pulse", killed, 1);
        check("kill_no_impact", impact, 0);
        check("kill_active", active, 0);
        check("kill_busy", busy, 1);
        check("kill_hold_y", missile_y, 439);
        seen_impact = 0; seen_kill = 0;
        repeat (CD - 1) begin
            @(negedge clk);
            if (impact) seen_impact++;
            if (killed) seen_kill++;
        end
        destroyed = 1'b0;
        check("kill_impact_never", seen_impact, 0);
        check("kill_single_pulse", seen_kill, 0);
        check("kill_cool_busy", busy, 1);
        @(negedge clk);
        check("kill_busy_fall", busy, 0);
        check("kill_end_impact", impact, 0);

        // Held launch_req on the MOVE_DIV=2 instance.
        target_sel = 3'd1; spawn_x = 10'd320; launch_req2 = 1'b1; frame_tick2 = 1'b1;
        @(negedge clk);
        check("div2_launch", active2, 1);
        steps = 0; guard = 0;
        while (active2 && guard < 3000) begin
            steps++;
            @(negedge clk);
            guard++;
        end
        check("div2_steps", steps, 880);
        check("div2_impact", impact2, 1);
        check("div2_final_y", missile_y2, GY);
        early = 0;
        repeat (CD) begin
            @(negedge clk);
            if (active2 || impact2) early++;
        end
        check("held_no_relaunch", early, 0);
        check("held_cool_busy", busy2, 1);
        @(negedge clk);
        check("held_idle_busy", busy2, 0);
        check("held_idle_active", active2, 0);
        @(negedge clk);
        check("held_relaunch", active2, 1);
        launch_req2 = 1'b0;
        frame_tick2 = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
